// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Bit timing is paced by an external oversampling tick; the serial line is a flop output.
module uart_tx_cfg #(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int NB_STOP    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic               o_tx_data,
    output logic               o_done
);

    localparam int TW = $clog2(SB_TICK);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_n;
    logic [TW-1:0]      tick_cnt, tick_cnt_n;
    logic [BW-1:0]      bit_cnt, bit_cnt_n;
    logic [NB_DATA-1:0] shreg, shreg_n;
    logic               par_bit, par_bit_n;
    logic               tx_reg, tx_n;
    logic               done_reg, done_n;
    logic               bit_end;

    function automatic logic frame_parity(input logic [NB_DATA-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign bit_end = i_tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        done_n     = 1'b0;

        // Tick counting is shared by every non-idle state; the bit advances on the last tick.
        if (state != IDLE && i_tick) begin
            tick_cnt_n = bit_end ? '0 : tick_cnt + TW'(1);
        end

        case (state)
            IDLE: begin
                if (i_valid) begin
                    shreg_n    = i_data;
                    par_bit_n  = frame_parity(i_data);
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is derived from the next state so the output flop carries it without delay.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_bit_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx_reg   <= tx_n;
            done_reg <= done_n;
        end
    end

    always_ff @(posedge i_clk) begin
        shreg   <= shreg_n;
        par_bit <= par_bit_n;
    end

    assign o_ready   = (state == IDLE);
    assign o_tx_data = tx_reg;
    assign o_done    = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: six configurations checked cycle by cycle against a
// tick-count model of the frame (bit index = ticks seen / SB_TICK).
module tb_uart_tx_cfg;

    localparam int N = 6;
    localparam int NBD [N] = '{8, 8, 8, 7, 9, 5};
    localparam int SBT [N] = '{16, 16, 16, 16, 8, 2};
    localparam int PEN [N] = '{0, 1, 1, 0, 1, 0};
    localparam int POD [N] = '{0, 0, 1, 0, 0, 0};
    localparam int NST [N] = '{1, 1, 1, 2, 1, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] valid, tick, tx, ready, done;
    logic [8:0]   data [N];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(1)) u0 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[0]), .i_valid(valid[0]), .i_data(data[0][7:0]),
        .o_ready(ready[0]), .o_tx_data(tx[0]), .o_done(done[0]));
    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0), .NB_STOP(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[1]), .i_valid(valid[1]), .i_data(data[1][7:0]),
        .o_ready(ready[1]), .o_tx_data(tx[1]), .o_done(done[1]));
    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1), .NB_STOP(1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[2]), .i_valid(valid[2]), .i_data(data[2][7:0]),
        .o_ready(ready[2]), .o_tx_data(tx[2]), .o_done(done[2]));
    uart_tx_cfg #(.NB_DATA(7), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(2)) u3 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[3]), .i_valid(valid[3]), .i_data(data[3][6:0]),
        .o_ready(ready[3]), .o_tx_data(tx[3]), .o_done(done[3]));
    uart_tx_cfg #(.NB_DATA(9), .SB_TICK(8), .PARITY_EN(1), .PARITY_ODD(0), .NB_STOP(1)) u4 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[4]), .i_valid(valid[4]), .i_data(data[4][8:0]),
        .o_ready(ready[4]), .o_tx_data(tx[4]), .o_done(done[4]));
    uart_tx_cfg #(.NB_DATA(5), .SB_TICK(2), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(1)) u5 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick[5]), .i_valid(valid[5]), .i_data(data[5][4:0]),
        .o_ready(ready[5]), .o_tx_data(tx[5]), .o_done(done[5]));

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s[u%0d] @%0t: got %0h, expected %0h", tag, idx, $time, obs, expv);
        end
    endtask

    // Frame as a list of line levels: start, data LSB first, parity, stop bits.
    function automatic logic exp_level(input int idx, input logic [8:0] w, input int b);
        logic p;
        if (b == 0) return 1'b0;
        if (b <= NBD[idx]) return w[b-1];
        if (PEN[idx] != 0 && b == NBD[idx] + 1) begin
            p = POD[idx][0];
            for (int k = 0; k < NBD[idx]; k++) p = p ^ w[k];
            return p;
        end
        return 1'b1;
    endfunction

    function automatic int frame_bits(input int idx);
        return 1 + NBD[idx] + PEN[idx] + NST[idx];
    endfunction

    task automatic idle(input int idx, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            valid[idx] = 1'b0;
            tick[idx]  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("idle_tx", idx, 32'(tx[idx]), 32'd1);
            check("idle_ready", idx, 32'(ready[idx]), 32'd1);
            check("idle_done", idx, 32'(done[idx]), 32'd0);
        end
        tick[idx] = 1'b0;
    endtask

    // Sends one word; ends at the sample point just after the final stop tick (o_done cycle).
    task automatic run_frame(input int idx, input logic [8:0] word, input int period,
                             input bit inject, input bit prefeed, input logic [8:0] nxt);
        int total, n, i, sbt;
        sbt   = SBT[idx];
        total = frame_bits(idx) * sbt;
        valid[idx] = 1'b1;
        data[idx]  = word;
        tick[idx]  = 1'b0;
        @(posedge clk); #1;
        valid[idx] = 1'b0;
        data[idx]  = 9'($urandom);
        check("accept_tx", idx, 32'(tx[idx]), 32'd0);
        check("accept_ready", idx, 32'(ready[idx]), 32'd0);
        check("accept_done", idx, 32'(done[idx]), 32'd0);
        n = 0;
        i = 0;
        while (n < total) begin
            i++;
            tick[idx] = ((i % period) == 0);
            if (inject) begin
                valid[idx] = (i >= 20 && i < 40);
                if (i == 20) data[idx] = 9'h0AA;
            end
            if (prefeed && n >= total - sbt) begin
                valid[idx] = 1'b1;
                data[idx]  = nxt;
            end
            @(posedge clk); #1;
            if (tick[idx]) n++;
            if (n < total) begin
                check("line", idx, 32'(tx[idx]), 32'(exp_level(idx, word, n / sbt)));
                check("busy_ready", idx, 32'(ready[idx]), 32'd0);
                check("busy_done", idx, 32'(done[idx]), 32'd0);
            end else begin
                check("end_done", idx, 32'(done[idx]), 32'd1);
                check("end_ready", idx, 32'(ready[idx]), 32'd1);
                check("end_tx", idx, 32'(tx[idx]), 32'd1);
            end
        end
        tick[idx] = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        tick  = '0;
        for (int k = 0; k < N; k++) data[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            check("rst_tx", k, 32'(tx[k]), 32'd1);
            check("rst_ready", k, 32'(ready[k]), 32'd1);
            check("rst_done", k, 32'(done[k]), 32'd0);
        end
        rst = 1'b0;
        idle(0, 4);

        // Baseline 8N1, then a word offered mid-frame must be ignored.
        run_frame(0, 9'h055, 1, 1'b0, 1'b0, 9'h0);
        idle(0, 3);
        run_frame(0, 9'h0C3, 1, 1'b1, 1'b0, 9'h0);
        idle(0, 3);

        // Word held through o_done starts with no idle gap.
        run_frame(0, 9'h0A5, 1, 1'b0, 1'b1, 9'h03C);
        run_frame(0, 9'h03C, 1, 1'b0, 1'b0, 9'h0);
        idle(0, 3);

        // Parity: even and odd sense.
        run_frame(1, 9'h007, 1, 1'b0, 1'b0, 9'h0);
        idle(1, 2);
        run_frame(1, 9'h000, 1, 1'b0, 1'b0, 9'h0);
        idle(1, 2);
        run_frame(2, 9'h007, 1, 1'b0, 1'b0, 9'h0);
        idle(2, 2);

        // Sparse tick with two stop bits.
        run_frame(3, 9'h041, 4, 1'b0, 1'b0, 9'h0);
        idle(3, 3);

        // Width extremes.
        run_frame(4, 9'h1FF, 1, 1'b0, 1'b0, 9'h0);
        idle(4, 2);
        run_frame(5, 9'h015, 1, 1'b0, 1'b0, 9'h0);
        idle(5, 2);

        // Reset during data bit 3 drops the frame.
        valid[0] = 1'b1;
        data[0]  = 9'h0C3;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        for (int i = 1; i <= 4 * 16 + 5; i++) begin
            tick[0] = 1'b1;
            @(posedge clk); #1;
            check("pre_rst_line", 0, 32'(tx[0]), 32'(exp_level(0, 9'h0C3, i / 16)));
        end
        tick[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_tx", 0, 32'(tx[0]), 32'd1);
        check("midrst_ready", 0, 32'(ready[0]), 32'd1);
        check("midrst_done", 0, 32'(done[0]), 32'd0);
        idle(0, 20);
        run_frame(0, 9'h0F0, 1, 1'b0, 1'b0, 9'h0);
        idle(0, 2);

        // Random words and tick spacing on every configuration.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                run_frame(k, 9'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0, 9'h0);
                idle(k, 2);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
